// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: stepped-frequency sweep sequencer feeding the DDS FCW input.
// Emits one FCW per accepted beat and advances the sweep on consumed samples,
// so a stalled DDS stretches the sweep rather than shortening dwells.
// Optional build macro: DDS_SWEEP_PINGPONG_EN adds a down leg after the up leg.
//
// Stream handshake: fcw_valid is high for the whole of RUN; a beat transfers
// on a rising clk edge where fcw_valid & fcw_ready. fcw_out and step_idx are
// held while a beat is waiting, and the sweep position advances only on a
// transferred beat, so the following beat already carries the next FCW.
module dds_sweep_ctrl #(
  parameter int G_FCW_WIDTH = 24,
  parameter int G_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic                   stop,
  input  logic [G_FCW_WIDTH-1:0] cfg_start_fcw,
  input  logic [G_FCW_WIDTH-1:0] cfg_step_fcw,
  input  logic [G_CNT_WIDTH-1:0] cfg_num_steps,
  input  logic [G_CNT_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_loop,
  output logic [G_FCW_WIDTH-1:0] fcw_out,
  output logic                   fcw_valid,
  input  logic                   fcw_ready,
  output logic                   busy,
  output logic                   done,
  output logic [G_CNT_WIDTH-1:0] step_idx,
  output logic [0:0]             dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [G_CNT_WIDTH-1:0] CNT_ONE = G_CNT_WIDTH'(1);

  logic [0:0]             state_q,     state_d;
  logic [G_FCW_WIDTH-1:0] fcw_q,       fcw_d;
  logic [G_CNT_WIDTH-1:0] step_idx_q,  step_idx_d;
  logic [G_CNT_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic                   done_q,      done_d;
  // Shadow copies of the configuration; steps/dwell are stored already
  // promoted from 0 to 1 so the run-time compares need no special case.
  logic [G_FCW_WIDTH-1:0] sh_start_q,  sh_start_d;
  logic [G_FCW_WIDTH-1:0] sh_step_q,   sh_step_d;
  logic [G_CNT_WIDTH-1:0] sh_steps_q,  sh_steps_d;
  logic [G_CNT_WIDTH-1:0] sh_dwell_q,  sh_dwell_d;
  logic                   sh_loop_q,   sh_loop_d;
`ifdef DDS_SWEEP_PINGPONG_EN
  logic                   dir_q,       dir_d;   // 0 = up leg, 1 = down leg
`endif

  logic beat;
  logic last_dwell;
  logic at_top;
  logic sweep_end;

  assign beat       = (state_q == S_RUN) && fcw_ready;
  assign last_dwell = (dwell_cnt_q == (sh_dwell_q - CNT_ONE));
  assign at_top     = (step_idx_q == (sh_steps_q - CNT_ONE));

  // Next-state, sweep position and shadow-register update.
  always_comb begin
    state_d     = state_q;
    fcw_d       = fcw_q;
    step_idx_d  = step_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    done_d      = 1'b0;
    sh_start_d  = sh_start_q;
    sh_step_d   = sh_step_q;
    sh_steps_d  = sh_steps_q;
    sh_dwell_d  = sh_dwell_q;
    sh_loop_d   = sh_loop_q;
    sweep_end   = 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
    dir_d       = dir_q;
`endif
    case (state_q)
      S_IDLE: begin
        // stop outranks start even while idle
        if (start && !stop) begin
          sh_start_d  = cfg_start_fcw;
          sh_step_d   = cfg_step_fcw;
          sh_steps_d  = (cfg_num_steps == '0) ? CNT_ONE : cfg_num_steps;
          sh_dwell_d  = (cfg_dwell == '0) ? CNT_ONE : cfg_dwell;
          sh_loop_d   = cfg_loop;
          state_d     = S_RUN;
          fcw_d       = cfg_start_fcw;
          step_idx_d  = '0;
          dwell_cnt_d = '0;
`ifdef DDS_SWEEP_PINGPONG_EN
          dir_d       = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (beat) begin
          if (!last_dwell) begin
            dwell_cnt_d = dwell_cnt_q + CNT_ONE;
          end else begin
            dwell_cnt_d = '0;
`ifdef DDS_SWEEP_PINGPONG_EN
            if (!dir_q) begin
              if (!at_top) begin
                fcw_d      = fcw_q + sh_step_q;
                step_idx_d = step_idx_q + CNT_ONE;
              end else if (sh_steps_q != CNT_ONE) begin
                // turn around without repeating the top step
                dir_d      = 1'b1;
                fcw_d      = fcw_q - sh_step_q;
                step_idx_d = step_idx_q - CNT_ONE;
              end else begin
                sweep_end  = 1'b1;
              end
            end else begin
              if (step_idx_q != '0) begin
                fcw_d      = fcw_q - sh_step_q;
                step_idx_d = step_idx_q - CNT_ONE;
              end else begin
                sweep_end  = 1'b1;
              end
            end
`else
            if (!at_top) begin
              fcw_d      = fcw_q + sh_step_q;
              step_idx_d = step_idx_q + CNT_ONE;
            end else begin
              sweep_end  = 1'b1;
            end
`endif
            if (sweep_end) begin
              if (sh_loop_q) begin
                fcw_d      = sh_start_q;
                step_idx_d = '0;
`ifdef DDS_SWEEP_PINGPONG_EN
                dir_d      = 1'b0;
`endif
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; enable low behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q     <= S_IDLE;
      fcw_q       <= '0;
      step_idx_q  <= '0;
      dwell_cnt_q <= '0;
      done_q      <= 1'b0;
      sh_start_q  <= '0;
      sh_step_q   <= '0;
      sh_steps_q  <= '0;
      sh_dwell_q  <= '0;
      sh_loop_q   <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fcw_q       <= fcw_d;
      step_idx_q  <= step_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      done_q      <= done_d;
      sh_start_q  <= sh_start_d;
      sh_step_q   <= sh_step_d;
      sh_steps_q  <= sh_steps_d;
      sh_dwell_q  <= sh_dwell_d;
      sh_loop_q   <= sh_loop_d;
`ifdef DDS_SWEEP_PINGPONG_EN
      dir_q       <= dir_d;
`endif
    end
  end

  assign fcw_out   = fcw_q;
  assign fcw_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign step_idx  = step_idx_q;
  assign dbg_state = state_q;

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer that drives the phase-increment (frequency control word, FCW) input of the Taylor-series DDS.
- Generates stepped frequency sweeps: start FCW, signed step, number of steps, dwell per step (in output samples).
- Emits one FCW beat per DDS sample over a valid/ready stream, so the dwell time counts consumed samples, not clocks.
- Sits between the register/config layer and the DDS din port.

Parameters:
G_FCW_WIDTH, 24, width of FCW output; must match DDS G_DIN_WIDTH.
G_CNT_WIDTH, 16, width of the step count, dwell and step index fields.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  0 forces IDLE and clears state (same effect as reset)
start  in  1  single-cycle pulse; latches cfg_* and begins sweep when IDLE
stop  in  1  abort sweep; return to IDLE
cfg_start_fcw  in  G_FCW_WIDTH  first FCW of sweep
cfg_step_fcw  in  G_FCW_WIDTH  signed two's-complement FCW increment per step
cfg_num_steps  in  G_CNT_WIDTH  number of frequency steps (0 treated as 1)
cfg_dwell  in  G_CNT_WIDTH  accepted beats per step (0 treated as 1)
cfg_loop  in  1  1 = restart sweep at end instead of finishing
fcw_out  out  G_FCW_WIDTH  FCW to DDS din
fcw_valid  out  1  FCW beat valid
fcw_ready  in  1  DDS din_ready
busy  out  1  high in RUN
done  out  1  one-cycle pulse at sweep completion
step_idx  out  G_CNT_WIDTH  index of current step

Behaviour:
- Reset or enable=0 (clk edge): state=IDLE; fcw_out=0, fcw_valid=0, busy=0, done=0, step_idx=0; internal counters 0.
- States: IDLE, RUN.
- IDLE:
  - start=1 latches all cfg_* into shadow registers.
  - Next cycle: state=RUN, busy=1, fcw_valid=1, fcw_out=cfg_start_fcw, step_idx=0, dwell_cnt=0.
  - start while RUN is ignored; cfg_* changes during RUN have no effect.
- RUN:
  - fcw_valid held at 1. A beat is transferred when fcw_valid & fcw_ready. fcw_out is stable while not accepted.
  - On each beat: dwell_cnt++.
  - When the beat is the last of the dwell (dwell_cnt = dwell_eff-1):
    - dwell_cnt=0.
    - If step_idx < steps_eff-1: fcw_out = fcw_out + step (mod 2^G_FCW_WIDTH, no saturation); step_idx++.
    - Else, end of sweep:
      - loop=1: fcw_out=start, step_idx=0, no done pulse; busy stays 1.
      - loop=0: next cycle state=IDLE, fcw_valid=0, busy=0, done=1 for exactly one cycle.
  - Update applies on the clock edge of the accepting beat, so the next beat carries the new FCW (zero bubble).
  - fcw_ready=0 freezes all counters.
- stop=1 in RUN: next cycle IDLE, fcw_valid=0, busy=0, no done pulse. The DDS accumulator tolerates valid deassertion mid-stream.
- stop has priority over start and over a same-cycle final beat. stop in IDLE is a no-op.
- Beats per sweep (loop=0) = steps_eff × dwell_eff.

Optional Feature:
Macro DDS_SWEEP_PINGPONG_EN.
- Defined:
  - After the last up step, direction reverses and the step is subtracted.
  - Down leg visits step indices steps_eff-2 down to 0 (endpoints not repeated).
  - step_idx counts down.
  - Sweep end (done or loop restart) occurs after index 0 of the down leg.
  - steps_eff=1 gives an empty down leg, which is identical to non-pingpong.
  - Total beats = (2·steps_eff−1)·dwell_eff.
- Undefined: sawtooth only, as described above; direction logic absent.

Test Plan:
- W=24, start=0x001000, step=0x000100, N=4, dwell=3, ready=1 → 12 beats: 3×0x001000, 3×0x001100, 3×0x001200, 3×0x001300. done pulse the cycle after the 12th beat; busy low same cycle.
- Same config, fcw_ready toggling 1,0,0,1… → identical 12-beat value sequence; fcw_out stable during stalls; done only after the 12th accepted beat.
- start=0xFFFF80, step=0x000100, N=3, dwell=1 → beats 0xFFFF80, 0x000080, 0x000180 (wrap). Negative step 0xFFFF00 from 0x000080 → 0xFFFF80.
- loop=1, N=2, dwell=2, start=0x10, step=0x10 → repeating 0x10,0x10,0x20,0x20,0x10…; no done pulse. stop asserted at beat 5 → valid low next cycle, busy=0, done stays 0.
- N=0, dwell=0 → exactly one beat of start FCW, then done. Reset asserted mid-sweep → all outputs 0 next cycle. Start pulse during RUN → ignored.
- With DDS_SWEEP_PINGPONG_EN, N=3, dwell=1, start=0x100, step=0x100 → 0x100,0x200,0x300,0x200,0x100, then done; step_idx sequence 0,1,2,1,0.
